// File: rtl/pwm_duty_ramp_pkg.sv
// Shared definitions for the duty ramp and its prescaler: duty width,
// FSM state encoding and the microsecond-to-clock-ticks conversion.
package pwm_duty_ramp_pkg;

    localparam int DUTY_W = 8;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RAMP = 1'b1
    } ramp_state_t;

    // Multiply before dividing so sub-MHz clocks still give a usable count.
    function automatic int us_to_ticks(input longint clk_hz, input longint us);
        return int'((clk_hz * us) / longint'(1_000_000));
    endfunction

endpackage

// File: rtl/pwm_duty_ramp_tick_gen.sv
// Parameterised prescaler: counts 0..TICKS-1 while enabled and flags the
// last count with a one-cycle tick. Synchronous clear wins over enable.
module pwm_duty_ramp_tick_gen #(
    parameter int TICKS = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int CW = (TICKS > 1) ? $clog2(TICKS) : 1;

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tick ? '0 : cnt + 1'b1;
        end
    end

    assign tick = (cnt == CW'(TICKS - 1));

endmodule

// File: rtl/pwm_duty_ramp.sv
// Slew-limited duty generator: walks the registered duty toward a loaded
// target by STEP_SIZE once per step interval, reporting busy and done.
module pwm_duty_ramp
    import pwm_duty_ramp_pkg::*;
#(
    parameter int CLK_FREQ_HZ    = 100000,
    parameter int STEP_PERIOD_US = 100,
    parameter int STEP_SIZE      = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              load,
    input  logic [DUTY_W-1:0] target,
    output logic [DUTY_W-1:0] duty,
    output logic              busy,
    output logic              done
);

    localparam int TICKS = us_to_ticks(CLK_FREQ_HZ, STEP_PERIOD_US);
    localparam logic [DUTY_W:0]   STEP9 = (DUTY_W + 1)'(STEP_SIZE);
    localparam logic [DUTY_W-1:0] STEP8 = DUTY_W'(STEP_SIZE);

    if (TICKS < 1) begin : g_bad_ticks
        $fatal(1, "pwm_duty_ramp: step interval is shorter than one clock");
    end
    if (STEP_SIZE < 1 || STEP_SIZE > 255) begin : g_bad_step
        $fatal(1, "pwm_duty_ramp: STEP_SIZE must be 1..255");
    end

    ramp_state_t       state, state_n;
    logic [DUTY_W-1:0] tgt, tgt_n, duty_n, eff_tgt;
    logic              done_n, pclr, step_tick;
    logic [DUTY_W:0]   diff, mag;

    pwm_duty_ramp_tick_gen #(
        .TICKS(TICKS)
    ) u_tick (
        .clk  (clk),
        .rst  (rst),
        .en   (state == ST_RAMP && enable),
        .clr  (pclr),
        .tick (step_tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            tgt   <= '0;
            duty  <= '0;
            done  <= 1'b0;
        end else begin
            state <= state_n;
            tgt   <= tgt_n;
            duty  <= duty_n;
            done  <= done_n;
        end
    end

    // A load coinciding with a step makes the step aim at the new target.
    always_comb begin
        eff_tgt = load ? target : tgt;
        state_n = state;
        tgt_n   = eff_tgt;
        duty_n  = duty;
        done_n  = 1'b0;
        pclr    = 1'b0;
        diff    = {1'b0, eff_tgt} - {1'b0, duty};
        mag     = diff[DUTY_W] ? (~diff + 1'b1) : diff;
        case (state)
            ST_IDLE: begin
                if (load) begin
                    if (target == duty) begin
                        done_n = 1'b1;
                    end else begin
                        state_n = ST_RAMP;
                        pclr    = 1'b1;
                    end
                end
            end
            ST_RAMP: begin
                // While frozen a retarget only latches; arrival is reported
                // on the first tick after enable returns.
                if (enable && load && target == duty) begin
                    state_n = ST_IDLE;
                    done_n  = 1'b1;
                end else if (enable && step_tick) begin
                    if (mag <= STEP9) begin
                        duty_n  = eff_tgt;
                        state_n = ST_IDLE;
                        done_n  = 1'b1;
                    end else if (diff[DUTY_W]) begin
                        duty_n = duty - STEP8;
                    end else begin
                        duty_n = duty + STEP8;
                    end
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_comb begin
        busy = (state == ST_RAMP);
    end

endmodule

// File: tb/tb_pwm_duty_ramp.sv
// Directed bench for pwm_duty_ramp: three instances (STEP_SIZE 1, 16, 100)
// exercised with hand-computed duty sequences and timing.
module tb_pwm_duty_ramp;

    logic       clk = 1'b0;
    logic       rst    [3];
    logic       enable [3];
    logic       load   [3];
    logic [7:0] target [3];
    logic [7:0] duty   [3];
    logic       busy   [3];
    logic       done   [3];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    pwm_duty_ramp #(.CLK_FREQ_HZ(100000), .STEP_PERIOD_US(100), .STEP_SIZE(1)) u_s1 (
        .clk(clk), .rst(rst[0]), .enable(enable[0]), .load(load[0]),
        .target(target[0]), .duty(duty[0]), .busy(busy[0]), .done(done[0]));

    pwm_duty_ramp #(.CLK_FREQ_HZ(100000), .STEP_PERIOD_US(100), .STEP_SIZE(16)) u_s16 (
        .clk(clk), .rst(rst[1]), .enable(enable[1]), .load(load[1]),
        .target(target[1]), .duty(duty[1]), .busy(busy[1]), .done(done[1]));

    pwm_duty_ramp #(.CLK_FREQ_HZ(100000), .STEP_PERIOD_US(100), .STEP_SIZE(100)) u_s100 (
        .clk(clk), .rst(rst[2]), .enable(enable[2]), .load(load[2]),
        .target(target[2]), .duty(duty[2]), .busy(busy[2]), .done(done[2]));

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input int d, input int t);
        load[d]   = 1'b1;
        target[d] = 8'(t);
        tick();
        load[d]   = 1'b0;
    endtask

    task automatic wait_done(input int d, input int max_cycles);
        int n = 0;
        while (!done[d] && n < max_cycles) begin
            tick();
            n++;
        end
        check("wait_done", int'(done[d]), 1);
    endtask

    int seq2[6] = '{112, 96, 80, 64, 48, 40};
    int seq3[3] = '{100, 200, 255};

    initial begin
        for (int i = 0; i < 3; i++) begin
            rst[i] = 1'b1; enable[i] = 1'b1; load[i] = 1'b0; target[i] = '0;
        end
        tick();
        for (int i = 0; i < 3; i++) rst[i] = 1'b0;

        // reset state
        check("rst_duty", duty[0], 0);
        check("rst_busy", int'(busy[0]), 0);
        check("rst_done", int'(done[0]), 0);

        // 0 -> 128 at step 1: +1 every 10 clocks, done at 1280
        do_load(0, 128);
        check("ramp1_busy_start", int'(busy[0]), 1);
        for (int k = 1; k <= 1280; k++) begin
            tick();
            check("ramp1_duty", duty[0], k / 10);
            check("ramp1_done", int'(done[0]), int'(k == 1280));
            check("ramp1_busy", int'(busy[0]), int'(k < 1280));
        end
        tick();
        check("ramp1_done_clear", int'(done[0]), 0);
        check("ramp1_hold", duty[0], 128);

        // step 16: up to 128, then down to 40 without undershoot
        do_load(1, 128);
        wait_done(1, 200);
        check("s16_up", duty[1], 128);
        do_load(1, 40);
        for (int i = 0; i < 6; i++) begin
            repeat (10) begin
                tick();
                check("s16_floor", int'(duty[1] >= 8'd40), 1);
            end
            check("s16_seq", duty[1], seq2[i]);
        end
        check("s16_done", int'(done[1]), 1);
        check("s16_busy", int'(busy[1]), 0);

        // step 100: 0 -> 255 clamps at the top
        do_load(2, 255);
        for (int i = 0; i < 3; i++) begin
            repeat (10) tick();
            check("s100_seq", duty[2], seq3[i]);
        end
        check("s100_done", int'(done[2]), 1);
        tick();
        check("s100_hold", duty[2], 255);

        // idle equal-target load still reports done while disabled
        enable[2] = 1'b0;
        do_load(2, 255);
        check("eq_done", int'(done[2]), 1);
        check("eq_busy", int'(busy[2]), 0);
        tick();
        check("eq_done_clear", int'(done[2]), 0);
        enable[2] = 1'b1;

        // retarget mid-ramp keeps cadence, then equal-target retarget stops
        rst[0] = 1'b1; tick(); rst[0] = 1'b0;
        do_load(0, 50);
        wait_done(0, 600);
        check("rt_start", duty[0], 50);
        do_load(0, 200);
        repeat (35) tick();
        check("rt_up", duty[0], 53);
        do_load(0, 30);
        repeat (3) tick();
        check("rt_before_tick", duty[0], 53);
        tick();
        check("rt_reverse", duty[0], 52);
        check("rt_busy", int'(busy[0]), 1);
        repeat (10) tick();
        check("rt_next", duty[0], 51);
        do_load(0, 51);
        check("rt_eq_done", int'(done[0]), 1);
        check("rt_eq_busy", int'(busy[0]), 0);
        check("rt_eq_duty", duty[0], 51);
        tick();
        check("rt_eq_done_clear", int'(done[0]), 0);

        // freeze for 37 cycles delays the next step by 37
        do_load(1, 200);
        repeat (13) tick();
        check("frz_first", duty[1], 56);
        enable[1] = 1'b0;
        repeat (37) begin
            tick();
            check("frz_hold", duty[1], 56);
            check("frz_done", int'(done[1]), 0);
        end
        enable[1] = 1'b1;
        repeat (6) begin
            tick();
            check("frz_resume_hold", duty[1], 56);
        end
        tick();
        check("frz_step", duty[1], 72);

        // reset mid-ramp at duty 90
        do_load(0, 100);
        repeat (390) tick();
        check("mr_duty90", duty[0], 90);
        check("mr_busy", int'(busy[0]), 1);
        rst[0] = 1'b1; tick(); rst[0] = 1'b0;
        check("mr_duty", duty[0], 0);
        check("mr_busy0", int'(busy[0]), 0);
        check("mr_done", int'(done[0]), 0);
        repeat (30) begin
            tick();
            check("mr_still", duty[0], 0);
            check("mr_still_busy", int'(busy[0]), 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
